// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO behind a valid/ready
// handshake feeding a start/data/stop serialiser with a fixed bit period.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          Tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          baud_done;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = tx_valid && !full;
    assign baud_done = (baud_q == BAUD_LAST);

    // A new frame is loaded from IDLE at once, or straight out of the last
    // stop-bit cycle so queued bytes stream without an idle gap.
    assign pop = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));

    assign tx_ready   = !full;
    assign busy       = (state_q != IDLE) || !empty;
    assign Tx         = tx_q;
    assign fifo_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage carries no reset; flushing is done by clearing pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo: a short-bit-period instance
// checked against a frame-schedule model and a line receiver, plus a default one.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_o;
    logic       busy;
    logic [2:0] fifo_count;

    logic [7:0] d_data = 8'h00;
    logic       d_valid = 1'b0;
    logic       d_ready;
    logic       d_tx;
    logic       d_busy;
    logic [2:0] d_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .Tx         (tx_o),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo dut_def (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (d_data),
        .tx_valid   (d_valid),
        .tx_ready   (d_ready),
        .Tx         (d_tx),
        .busy       (d_busy),
        .fifo_count (d_count)
    );

    // Line level of an 8N1 frame t cycles after its start edge.
    function automatic logic frame_bit(input logic [7:0] b, input int t, input int cpb);
        int pos;
        pos = t / cpb;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        return 1'b1;
    endfunction

    // Reference model: a byte queue plus the time the line becomes free.
    logic [7:0] m_q[$];
    longint     cyc = 0;
    longint     m_free_at = 0;
    longint     act_start = 0;
    logic [7:0] act_data = 8'h00;
    bit         active = 1'b0;
    bit         m_push, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_free_at = 0;
            active    = 1'b0;
        end else begin
            m_push = (tx_valid === 1'b1) && (m_q.size() < DEP);
            m_pop  = (m_q.size() != 0) && (cyc >= m_free_at);
            if (m_pop) begin
                act_data  = m_q.pop_front();
                act_start = cyc;
                active    = 1'b1;
                m_free_at = cyc + 10 * CPB;
            end
            if (m_push) m_q.push_back(tx_data);
            cyc++;
        end
    end

    bit    mon_en = 1'b0;
    int    mon_err = 0;
    string mon_first = "";
    int    max_count = 0;

    always @(negedge clk) begin
        longint t;
        int     sz;
        logic   e_tx, e_busy;
        if (mon_en) begin
            sz     = m_q.size();
            t      = cyc - 1 - act_start;
            e_tx   = (active && t < 10 * CPB) ? frame_bit(act_data, int'(t), CPB) : 1'b1;
            e_busy = (sz != 0) || (active && t < 10 * CPB);
            if (tx_o !== e_tx || busy !== e_busy || tx_ready !== (sz < DEP) || fifo_count !== 3'(sz)) begin
                if (mon_err == 0)
                    mon_first = $sformatf("t=%0t Tx %b/%b busy %b/%b ready %b/%b count %0d/%0d",
                                          $time, tx_o, e_tx, busy, e_busy, tx_ready, sz < DEP, fifo_count, sz);
                mon_err++;
            end
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
    end

    // Independent line receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    int         rx_stop_bad = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_o === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if ((rx_t % CPB) == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
                rx_sh[rx_t / CPB - 1] = tx_o;
            if (rx_t == 10 * CPB - CPB / 2) begin
                rx_q.push_back(rx_sh);
                if (tx_o !== 1'b1) rx_stop_bad++;
            end
            if (rx_t == 10 * CPB - 1) rx_act = 1'b0;
        end
    end

    logic [7:0] sent_q[$];
    int         stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic mon_check(input string tag);
        #1;
        chk(tag, mon_err, 0);
        if (mon_err != 0) $display("  first divergence: %s", mon_first);
        mon_err = 0;
    endtask

    // Offer b from the next falling edge; returns right after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        while (tx_ready !== 1'b1) begin
            if (n >= 400) begin
                chk("push_timeout", 0, 1);
                tx_valid = 1'b0;
                return;
            end
            stalls++;
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        sent_q.push_back(b);
    endtask

    task automatic wait_idle(input int limit, output longint t_idle);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0) begin
            if (n >= limit) begin
                chk("idle_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            n++;
        end
        t_idle = $time;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_count"}, rx_q.size(), sent_q.size());
        chk({tag, "_stop_bits"}, rx_stop_bad, 0);
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
            $display("%s byte %0d sent %02h received %02h", tag, i, sent_q[i], rx_q[i]);
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], sent_q[i]);
        end
        sent_q.delete();
        rx_q.delete();
        rx_stop_bad = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, ti;
        int     bad, lows, bb;

        // Reset held 4 cycles, checked asynchronously.
        #1 rst = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_def_tx", d_tx, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle hold: 1000 cycles without pushes.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy !== 1'b0 || d_tx !== 1'b1 || d_busy !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);
        mon_check("idle_model");

        // Single byte 0xA5: start edge one cycle after the push, 40-cycle frame.
        push_byte(8'hA5);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("a5_prestart_tx", tx_o, 1);
        @(posedge clk);
        t1 = $time;
        #1 chk("a5_start_edge", tx_o, 0);
        wait_idle(100, ti);
        chk("a5_frame_len", (ti - 5 - t1) / 10, 40);
        check_rx("a5");
        mon_check("a5_model");

        // Burst 0x01..0x06 with tx_valid held.
        max_count = 0;
        stalls    = 0;
        push_byte(8'h01);
        t0 = $time;
        for (int i = 2; i <= 6; i++) push_byte(8'(i));
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(600, ti);
        chk("burst_stall_cycles", stalls, 37);
        chk("burst_total", (ti - 5 - t0) / 10 - 1, 240);
        chk("burst_max_count", max_count, 4);
        check_rx("burst");
        mon_check("burst_model");

        // Reset asserted mid-frame with bytes still queued.
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_tx", tx_o, 1);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", fifo_count, 0);
        sent_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("midrst_no_residual", lows, 0);
        chk("midrst_no_rx", rx_q.size(), 0);
        rx_q.delete();
        mon_check("midrst_model");

        // Randomized bytes and gaps, repeatedly hitting full at the pop edge.
        max_count = 0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                tx_valid = 1'b0;
                repeat ($urandom_range(0, 60)) @(negedge clk);
            end
            push_byte(8'($urandom));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(1500, ti);
        chk("rand_max_count_le4", max_count <= 4, 1);
        check_rx("rand");
        mon_check("rand_model");

        // Default bit period: byte 0x02.
        @(negedge clk);
        d_valid = 1'b1;
        d_data  = 8'h02;
        chk("def_ready", d_ready, 1);
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        chk("def_prestart_tx", d_tx, 1);
        bad  = 0;
        lows = 0;
        bb   = 0;
        for (int t = 0; t < 52080; t++) begin
            @(negedge clk);
            if (d_tx !== frame_bit(8'h02, t, 5208)) bad++;
            if (d_tx === 1'b0) lows++;
            if (d_busy !== 1'b1) bb++;
        end
        @(negedge clk);
        $display("default frame 0x02: bit errors %0d low cycles %0d", bad, lows);
        chk("def_bits", bad, 0);
        chk("def_low_cycles", lows, 41664);
        chk("def_busy_during", bb, 0);
        chk("def_busy_end", d_busy, 0);
        chk("def_tx_end", d_tx, 1);
        chk("def_count_end", d_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
